idma_obi_write_tracker: RTL and testbench

//  Write-side OBI manager for the iDMA backend. It accepts write beats (addr/data/strobe/last) from the dataflow element
//  and issues them as OBI A-channel writes, with up to MaxOutstanding writes in flight. It collects in-order R responses
//  and returns one response per burst (beat tagged last) with a sticky error flag. This gives bus-level pipelining and error reporting.

---
 rtl/idma_obi_write_tracker.sv | 136 +++++++++++++
 tb/tb_idma_obi_write_tracker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_obi_write_tracker.sv
// Write-side OBI manager: issues write beats as OBI A-channel requests with bounded
// outstanding count and folds in-order R responses into one response per burst.
module idma_obi_write_tracker #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 1,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ErrorSupport   = 1,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IdWidth-1:0]   aid_i,
  input  logic                 beat_valid_i,
  output logic                 beat_ready_o,
  input  logic [AddrWidth-1:0] beat_addr_i,
  input  logic [DataWidth-1:0] beat_data_i,
  input  logic [StrbWidth-1:0] beat_strb_i,
  input  logic                 beat_last_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [StrbWidth-1:0] obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  output logic [IdWidth-1:0]   obi_aid_o,
  input  logic                 obi_rvalid_i,
  output logic                 obi_rready_o,
  input  logic                 obi_err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_error_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 busy_o
);

  localparam int unsigned        PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxOutstanding - 1);
  localparam logic                ErrEn   = (ErrorSupport != 0);

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_e;

  state_e                    r_state;
  logic [CntWidth-1:0]       r_cnt;
  logic [MaxOutstanding-1:0] r_last_fifo;
  logic [PtrWidth-1:0]       r_wptr;
  logic [PtrWidth-1:0]       r_rptr;
  logic                      r_err_acc;
  logic                      r_rsp_error;

  logic w_a_hs;
  logic w_r_hs;
  logic w_r_take;
  logic w_pop_last;
  logic w_err;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrWidth'(1);
  endfunction

  // A channel is a zero-latency pass-through gated only by the outstanding limit
  assign obi_req_o    = beat_valid_i & (r_cnt < MaxCnt);
  assign beat_ready_o = obi_req_o & obi_gnt_i;
  assign obi_addr_o   = beat_addr_i;
  assign obi_be_o     = beat_strb_i;
  assign obi_wdata_o  = beat_data_i;
  assign obi_aid_o    = aid_i;
  assign obi_we_o     = 1'b1;

  assign obi_rready_o = (r_state == IDLE) | rsp_ready_i;
  assign w_a_hs       = beat_ready_o;
  assign w_r_hs       = obi_rvalid_i & obi_rready_o;
  // A stray response with nothing in flight must not disturb any state
  assign w_r_take     = w_r_hs & (r_cnt != '0);
  assign w_pop_last   = r_last_fifo[r_rptr];
  assign w_err        = ErrEn & obi_err_i;

  assign rsp_valid_o   = (r_state == RSP);
  assign rsp_error_o   = r_rsp_error;
  assign outstanding_o = r_cnt;
  assign busy_o        = (r_cnt != '0) | rsp_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_last_fifo <= '0;
    end else begin
      if (w_a_hs) begin
        r_last_fifo[r_wptr] <= beat_last_i;
        r_wptr              <= ptr_inc(r_wptr);
      end
      if (w_r_take) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_a_hs && !w_r_take) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end else if (!w_a_hs && w_r_take) begin
        r_cnt <= r_cnt - CntWidth'(1);
      end
    end
  end

  // A last-beat response taken while RSP is being acknowledged re-arms RSP directly
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_err_acc   <= 1'b0;
      r_rsp_error <= 1'b0;
    end else begin
      if (w_r_take && w_pop_last) begin
        r_rsp_error <= r_err_acc | w_err;
        r_err_acc   <= 1'b0;
        r_state     <= RSP;
      end else begin
        if (w_r_take) begin
          r_err_acc <= r_err_acc | w_err;
        end
        if ((r_state == RSP) && rsp_ready_i) begin
          r_state <= IDLE;
        end
      end
    end
  end

  a_no_rsp_without_outstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(w_r_hs && (r_cnt == '0))
  );

endmodule

// File: tb/tb_idma_obi_write_tracker.sv
// Bench for idma_obi_write_tracker: scripted subordinate, A-beat and burst-response
// scoreboards, plus an ErrorSupport=0 instance fed the same stimulus.
module tb_idma_obi_write_tracker;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        err;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        aid_i = 1'b1;
  logic        beat_valid_i = 1'b0;
  logic        beat_ready_o;
  logic [31:0] beat_addr_i = '0;
  logic [31:0] beat_data_i = '0;
  logic [3:0]  beat_strb_i = '0;
  logic        beat_last_i = 1'b0;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_aid_o;
  logic        obi_rvalid_i = 1'b0;
  logic        obi_rready_o;
  logic        obi_err_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic        rsp_error_o;
  logic [2:0]  outstanding_o;
  logic        busy_o;

  logic        d0_beat_ready, d0_req, d0_we, d0_aid, d0_rready;
  logic        d0_rsp_valid, d0_rsp_error, d0_busy;
  logic [31:0] d0_addr, d0_wdata;
  logic [3:0]  d0_be;
  logic [2:0]  d0_out;

  logic        r_en = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int unsigned a_cnt = 0;
  beat_t       drv_q[$];
  beat_t       pend_q[$];
  beat_t       exp_a[$];
  logic        exp_rsp[$];

  always #5 clk_i = ~clk_i;

  idma_obi_write_tracker #(.MaxOutstanding(4), .ErrorSupport(1)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .aid_i(aid_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o), .beat_addr_i(beat_addr_i),
    .beat_data_i(beat_data_i), .beat_strb_i(beat_strb_i), .beat_last_i(beat_last_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_aid_o(obi_aid_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o), .obi_err_i(obi_err_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_error_o(rsp_error_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  idma_obi_write_tracker #(.MaxOutstanding(4), .ErrorSupport(0)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .aid_i(aid_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(d0_beat_ready), .beat_addr_i(beat_addr_i),
    .beat_data_i(beat_data_i), .beat_strb_i(beat_strb_i), .beat_last_i(beat_last_i),
    .obi_req_o(d0_req), .obi_gnt_i(obi_gnt_i), .obi_addr_o(d0_addr), .obi_we_o(d0_we),
    .obi_be_o(d0_be), .obi_wdata_o(d0_wdata), .obi_aid_o(d0_aid),
    .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(d0_rready), .obi_err_i(obi_err_i),
    .rsp_valid_o(d0_rsp_valid), .rsp_ready_i(rsp_ready_i), .rsp_error_o(d0_rsp_error),
    .outstanding_o(d0_out), .busy_o(d0_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push_burst(input int unsigned n, input logic [31:0] base,
                            input logic [7:0] errmask, input logic exp_err);
    beat_t b;
    for (int unsigned i = 0; i < n; i++) begin
      b.addr = base + 32'(4 * i);
      b.data = {base[31:16] ^ 16'hA5C3, 16'(i + 1) ^ base[15:0]};
      b.strb = 4'(4'hF >> (i % 4));
      b.last = (i == n - 1);
      b.err  = errmask[i];
      drv_q.push_back(b);
      exp_a.push_back(b);
    end
    exp_rsp.push_back(exp_err);
  endtask

  task automatic wait_idle(input string nm);
    int unsigned n = 0;
    while ((drv_q.size() != 0 || exp_rsp.size() != 0 || busy_o) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk({nm, "_drain"}, 32'(n < 300), 1);
  endtask

  // Subordinate model, A-beat scoreboard and burst-response monitor
  initial begin
    logic  a_fire, r_fire, last_r_prev, ex;
    beat_t e;
    last_r_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      a_fire = rst_ni & beat_valid_i & beat_ready_o;
      r_fire = rst_ni & obi_rvalid_i & obi_rready_o;
      if (rst_ni) begin
        if (last_r_prev) chk("rsp_after_last_r", 32'(rsp_valid_o), 1);
        if (a_fire) begin
          a_cnt++;
          chk("a_expected", 32'(exp_a.size() != 0), 1);
          if (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            chk("a_addr", obi_addr_o, e.addr);
            chk("a_wdata", obi_wdata_o, e.data);
            chk("a_be", 32'(obi_be_o), 32'(e.strb));
            chk("a_we", 32'(obi_we_o), 1);
            chk("a_aid", 32'(obi_aid_o), 1);
          end
        end
        if (rsp_valid_o && rsp_ready_i) begin
          chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
          if (exp_rsp.size() != 0) begin
            ex = exp_rsp.pop_front();
            chk("rsp_error", 32'(rsp_error_o), 32'(ex));
          end
          chk("rsp0_valid", 32'(d0_rsp_valid), 1);
          chk("rsp0_error", 32'(d0_rsp_error), 0);
        end
        last_r_prev = r_fire && (pend_q.size() != 0) && pend_q[0].last;
      end else begin
        last_r_prev = 1'b0;
      end
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        pend_q.delete();
      end else begin
        if (a_fire && drv_q.size() != 0) pend_q.push_back(drv_q.pop_front());
        if (r_fire && pend_q.size() != 0) void'(pend_q.pop_front());
      end
      beat_valid_i = rst_ni && (drv_q.size() != 0);
      if (drv_q.size() != 0) begin
        beat_addr_i = drv_q[0].addr;
        beat_data_i = drv_q[0].data;
        beat_strb_i = drv_q[0].strb;
        beat_last_i = drv_q[0].last;
      end
      obi_rvalid_i = rst_ni && r_en && (pend_q.size() != 0);
      obi_err_i    = (pend_q.size() != 0) ? pend_q[0].err : 1'b0;
    end
  end

  initial begin
    int unsigned a0, n, peak;
    repeat (3) @(negedge clk_i);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_rsp_error", 32'(rsp_error_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_outstanding", 32'(outstanding_o), 0);
    chk("rst_req", 32'(obi_req_o), 0);
    #1 rst_ni = 1'b1;

    // 1) three-beat burst, immediate grant, R one cycle after grant
    step();
    obi_gnt_i = 1'b1;
    r_en = 1'b1;
    a0 = a_cnt;
    peak = 0;
    n = 0;
    push_burst(3, 32'h1000_0000, 8'h00, 1'b0);
    do begin
      @(negedge clk_i);
      if (32'(outstanding_o) > peak) peak = 32'(outstanding_o);
      n++;
    end while ((busy_o || drv_q.size() != 0 || exp_rsp.size() != 0) && n < 100);
    chk("t1_drain", 32'(n < 100), 1);
    chk("t1_beats", a_cnt - a0, 3);
    chk("t1_peak", peak, 1);

    // 2) R withheld: only four beats may be granted
    step();
    r_en = 1'b0;
    a0 = a_cnt;
    push_burst(6, 32'h2000_0000, 8'h00, 1'b0);
    repeat (8) @(negedge clk_i);
    chk("t2_granted", a_cnt - a0, 4);
    chk("t2_req_full", 32'(obi_req_o), 0);
    chk("t2_out_full", 32'(outstanding_o), 4);
    r_en = 1'b1;
    @(negedge clk_i);
    chk("t2_req_no_bypass", 32'(obi_req_o), 0);
    chk("t2_r_fire", 32'(obi_rvalid_i & obi_rready_o), 1);
    r_en = 1'b0;
    @(negedge clk_i);
    chk("t2_fifth_issue", 32'(obi_req_o & obi_gnt_i), 1);
    chk("t2_out_after_r", 32'(outstanding_o), 3);
    r_en = 1'b1;
    wait_idle("t2");

    // 3) error on first beat of a two-beat burst only
    step();
    push_burst(2, 32'h3000_0000, 8'h01, 1'b1);
    push_burst(1, 32'h3000_0100, 8'h00, 1'b0);
    wait_idle("t3");

    // 4) response back-pressure holds the next last-beat R
    step();
    rsp_ready_i = 1'b0;
    push_burst(1, 32'h4000_0000, 8'h00, 1'b0);
    push_burst(1, 32'h4000_0010, 8'h01, 1'b1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!rsp_valid_o && n < 50);
    chk("t4_rsp_seen", 32'(n < 50), 1);
    repeat (5) begin
      @(negedge clk_i);
      chk("t4_rready_low", 32'(obi_rready_o), 0);
      chk("t4_out_held", 32'(outstanding_o), 1);
      chk("t4_rsp_stable", 32'(rsp_valid_o), 1);
    end
    step();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t4_second_valid", 32'(rsp_valid_o), 1);
    chk("t4_second_error", 32'(rsp_error_o), 1);
    wait_idle("t4");

    // 5) simultaneous A and R handshakes at two outstanding
    step();
    obi_gnt_i = 1'b0;
    r_en = 1'b0;
    push_burst(4, 32'h5000_0000, 8'h00, 1'b0);
    step();
    obi_gnt_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (outstanding_o != 3'd1 && n < 50);
    chk("t5_reach_one", 32'(n < 50), 1);
    r_en = 1'b1;
    @(negedge clk_i);
    chk("t5_out_two", 32'(outstanding_o), 2);
    chk("t5_a_fire", 32'(obi_req_o & obi_gnt_i), 1);
    chk("t5_r_fire", 32'(obi_rvalid_i & obi_rready_o), 1);
    r_en = 1'b0;
    @(negedge clk_i);
    chk("t5_out_same", 32'(outstanding_o), 2);
    r_en = 1'b1;
    wait_idle("t5");

    // 6) reset with three writes in flight and a pending response
    step();
    rsp_ready_i = 1'b0;
    r_en = 1'b0;
    a0 = a_cnt;
    push_burst(1, 32'h6000_0000, 8'h00, 1'b0);
    push_burst(3, 32'h6000_0100, 8'h00, 1'b0);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (a_cnt - a0 != 4 && n < 50);
    chk("t6_all_issued", 32'(n < 50), 1);
    r_en = 1'b1;
    @(negedge clk_i);
    r_en = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("t6_rsp_pending", 32'(rsp_valid_o), 1);
    chk("t6_out_three", 32'(outstanding_o), 3);
    #1 rst_ni = 1'b0;
    #1;
    chk("t6_rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("t6_rst_rsp_error", 32'(rsp_error_o), 0);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_out", 32'(outstanding_o), 0);
    chk("t6_rst_req", 32'(obi_req_o), 0);
    exp_rsp.delete();
    exp_a.delete();
    drv_q.delete();
    repeat (2) @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    r_en = 1'b1;
    push_burst(1, 32'h7000_0000, 8'h01, 1'b1);
    wait_idle("t6_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
